// File: rtl/mpu_matrix_regfile.sv
// Matrix register file for the MPU. It has independent streaming load and store ports, so one
// matrix can fill while another drains, and it tracks validity and dimensions per register.
module mpu_matrix_regfile #(
  parameter int FP               = 32,
  parameter int MAX_M            = 3,
  parameter int MAX_N            = 3,
  parameter int MATRIX_REGISTERS = 16,
  localparam int RB = $clog2(MATRIX_REGISTERS),
  localparam int DB = $clog2(MAX_M + 1),
  localparam int NB = $clog2(MAX_N + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          ld_start,
  input  logic [RB-1:0] ld_reg,
  input  logic [DB-1:0] ld_m,
  input  logic [NB-1:0] ld_n,
  input  logic          ld_valid,
  input  logic [FP-1:0] ld_data,
  output logic          ld_ready,
  output logic          ld_busy,
  output logic          ld_done,
  output logic          ld_err,
  input  logic          st_start,
  input  logic [RB-1:0] st_reg,
  input  logic          st_ready,
  output logic          st_valid,
  output logic [FP-1:0] st_data,
  output logic [DB-1:0] st_row,
  output logic [NB-1:0] st_col,
  output logic          st_last,
  output logic [DB-1:0] st_m,
  output logic [NB-1:0] st_n,
  output logic          st_busy,
  output logic          st_err
);

  localparam int ELEMS = MAX_M * MAX_N;
  localparam int IW    = $clog2(ELEMS + 1);

  typedef enum logic {LOAD_IDLE, LOAD_MATRIX} ld_state_e;
  typedef enum logic [1:0] {STORE_IDLE, STORE_WAIT, STORE_MATRIX} st_state_e;

  ld_state_e ld_state, ld_state_nx;
  st_state_e st_state, st_state_nx;

  logic [RB-1:0]               ld_reg_q, st_reg_q;
  logic [DB-1:0]               ld_m_q, ld_row, st_row_q;
  logic [NB-1:0]               ld_n_q, ld_col, st_col_q;
  logic [MATRIX_REGISTERS-1:0] valid_q;
  logic [DB-1:0]               dim_m [MATRIX_REGISTERS];
  logic [NB-1:0]               dim_n [MATRIX_REGISTERS];
  logic [FP-1:0]               mem   [MATRIX_REGISTERS][ELEMS];
  logic                        ld_done_q, ld_err_q, st_err_q;

  logic clear_ok, ld_dims_ok, ld_conflict, ld_accept, ld_beat, ld_last;
  logic st_wait, st_accept, st_beat, st_last_int;

  function automatic logic [IW-1:0] idx(input logic [DB-1:0] r, input logic [NB-1:0] c);
    return IW'(r) * IW'(MAX_N) + IW'(c);
  endfunction

  // NOTE: every signal written in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    clear_ok    = clear && (ld_state == LOAD_IDLE) && (st_state == STORE_IDLE);
    ld_dims_ok  = (ld_m != '0) && (ld_m <= DB'(MAX_M)) && (ld_n != '0) && (ld_n <= NB'(MAX_N));
    ld_conflict = (st_state != STORE_IDLE) && (st_reg_q == ld_reg);
    ld_accept   = ld_start && (ld_state == LOAD_IDLE) && ld_dims_ok && !ld_conflict;
    ld_beat     = (ld_state == LOAD_MATRIX) && ld_valid;
    ld_last     = (ld_row == ld_m_q - DB'(1)) && (ld_col == ld_n_q - NB'(1));
    // A store aimed at the register being filled (or being accepted this cycle) waits for it.
    st_wait     = ((ld_state == LOAD_MATRIX) && (ld_reg_q == st_reg)) ||
                  (ld_accept && (ld_reg == st_reg));
    st_accept   = st_start && (st_state == STORE_IDLE) &&
                  (st_wait || (valid_q[st_reg] && !clear_ok));
    st_beat     = (st_state == STORE_MATRIX) && st_ready;
    st_last_int = (st_state == STORE_MATRIX) &&
                  (st_row_q == dim_m[st_reg_q] - DB'(1)) &&
                  (st_col_q == dim_n[st_reg_q] - NB'(1));
  end

  always_comb begin
    ld_state_nx = ld_state;
    unique case (ld_state)
      LOAD_IDLE:   if (ld_accept)          ld_state_nx = LOAD_MATRIX;
      LOAD_MATRIX: if (ld_beat && ld_last) ld_state_nx = LOAD_IDLE;
    endcase
    st_state_nx = st_state;
    case (st_state)
      STORE_IDLE:   if (st_accept)              st_state_nx = st_wait ? STORE_WAIT : STORE_MATRIX;
      STORE_WAIT:   if (ld_done_q)              st_state_nx = STORE_MATRIX;
      STORE_MATRIX: if (st_beat && st_last_int) st_state_nx = STORE_IDLE;
      default:                                  st_state_nx = STORE_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_state <= LOAD_IDLE;
      st_state <= STORE_IDLE;
    end else begin
      ld_state <= ld_state_nx;
      st_state <= st_state_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_reg_q  <= '0;
      ld_m_q    <= '0;
      ld_n_q    <= '0;
      ld_row    <= '0;
      ld_col    <= '0;
      st_reg_q  <= '0;
      st_row_q  <= '0;
      st_col_q  <= '0;
      valid_q   <= '0;
      ld_done_q <= 1'b0;
      ld_err_q  <= 1'b0;
      st_err_q  <= 1'b0;
      for (int i = 0; i < MATRIX_REGISTERS; i++) begin
        dim_m[i] <= '0;
        dim_n[i] <= '0;
      end
    end else begin
      ld_done_q <= ld_beat && ld_last;
      ld_err_q  <= ld_start && !ld_accept;
      st_err_q  <= st_start && !st_accept;
      if (clear_ok) valid_q <= '0;

      if (ld_accept) begin
        ld_reg_q        <= ld_reg;
        ld_m_q          <= ld_m;
        ld_n_q          <= ld_n;
        ld_row          <= '0;
        ld_col          <= '0;
        valid_q[ld_reg] <= 1'b0;
      end
      if (ld_beat) begin
        if (ld_last) begin
          valid_q[ld_reg_q] <= 1'b1;
          dim_m[ld_reg_q]   <= ld_m_q;
          dim_n[ld_reg_q]   <= ld_n_q;
          ld_row            <= '0;
          ld_col            <= '0;
        end else if (ld_col == ld_n_q - NB'(1)) begin
          ld_col <= '0;
          ld_row <= ld_row + DB'(1);
        end else begin
          ld_col <= ld_col + NB'(1);
        end
      end

      if (st_accept) begin
        st_reg_q <= st_reg;
        st_row_q <= '0;
        st_col_q <= '0;
      end
      if (st_beat) begin
        if (st_last_int) begin
          st_row_q <= '0;
          st_col_q <= '0;
        end else if (st_col_q == dim_n[st_reg_q] - NB'(1)) begin
          st_col_q <= '0;
          st_row_q <= st_row_q + DB'(1);
        end else begin
          st_col_q <= st_col_q + NB'(1);
        end
      end
    end
  end

  // NOTE: the element array has no reset; validity bits alone say whether its contents mean anything.
  always_ff @(posedge clk) begin
    if (ld_beat) mem[ld_reg_q][idx(ld_row, ld_col)] <= ld_data;
  end

  always_comb begin
    ld_ready = (ld_state == LOAD_MATRIX);
    ld_busy  = (ld_state != LOAD_IDLE);
    ld_done  = ld_done_q;
    ld_err   = ld_err_q;
    st_valid = (st_state == STORE_MATRIX);
    st_busy  = (st_state != STORE_IDLE);
    st_err   = st_err_q;
    st_data  = '0;
    st_row   = '0;
    st_col   = '0;
    st_last  = 1'b0;
    st_m     = '0;
    st_n     = '0;
    if (st_state == STORE_MATRIX) begin
      st_data = mem[st_reg_q][idx(st_row_q, st_col_q)];
      st_row  = st_row_q;
      st_col  = st_col_q;
      st_last = st_last_int;
      st_m    = dim_m[st_reg_q];
      st_n    = dim_n[st_reg_q];
    end
  end

endmodule

// File: tb/tb_mpu_matrix_regfile.sv
// Bench for mpu_matrix_regfile: directed loads/stores, store beats checked against a scoreboard
// queue by an independent monitor.
module tb_mpu_matrix_regfile;

  localparam int FP = 32, MAX_N = 3, RB = 4, DB = 2, NB = 2;

  logic          clk = 1'b0, rst_n = 1'b0, clear = 1'b0;
  logic          ld_start = 1'b0, ld_valid = 1'b0;
  logic [RB-1:0] ld_reg = '0;
  logic [DB-1:0] ld_m = '0;
  logic [NB-1:0] ld_n = '0;
  logic [FP-1:0] ld_data = '0;
  logic          ld_ready, ld_busy, ld_done, ld_err;
  logic          st_start = 1'b0, st_ready = 1'b0;
  logic [RB-1:0] st_reg = '0;
  logic          st_valid, st_last, st_busy, st_err;
  logic [FP-1:0] st_data;
  logic [DB-1:0] st_row, st_m;
  logic [NB-1:0] st_col, st_n;

  mpu_matrix_regfile dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .ld_start(ld_start), .ld_reg(ld_reg), .ld_m(ld_m), .ld_n(ld_n),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready), .ld_busy(ld_busy),
    .ld_done(ld_done), .ld_err(ld_err),
    .st_start(st_start), .st_reg(st_reg), .st_ready(st_ready), .st_valid(st_valid),
    .st_data(st_data), .st_row(st_row), .st_col(st_col), .st_last(st_last),
    .st_m(st_m), .st_n(st_n), .st_busy(st_busy), .st_err(st_err)
  );

  always #5 clk = ~clk;

  typedef logic [40:0] beat_t;   // {data, row, col, last, m, n}
  beat_t       exp_q[$];
  logic [31:0] mdl [16][9];
  int          mdl_m [16];
  int          mdl_n [16];
  logic [31:0] v [9];
  int          n_checks = 0, n_pass = 0;
  bit          rdy_rand = 1'b0;
  bit          early;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [63:0] outs();
    return 64'({ld_ready, ld_busy, ld_done, ld_err, st_valid, st_data, st_row, st_col,
                st_last, st_m, st_n, st_busy, st_err});
  endfunction

  initial begin
    forever begin
      @(posedge clk); #1;
      st_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: every accepted store beat must match the head of the scoreboard.
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      if (st_valid && st_ready) begin
        if (exp_q.size() == 0) check("st_beat_unexpected", 64'(1), 64'(0));
        else begin
          e = exp_q.pop_front();
          check("st_beat", 64'({st_data, st_row, st_col, st_last, st_m, st_n}), 64'(e));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic load_matrix(input int r, input int m, input int n, input bit rnd,
                             input int exp_lat, input bit poke);
    int k = 0, cyc = 0;
    bit hs;
    ld_start = 1'b1; ld_reg = RB'(r); ld_m = DB'(m); ld_n = NB'(n);
    for (int i = 0; i < m * n; i++) mdl[r][(i / n) * MAX_N + (i % n)] = v[i];
    mdl_m[r] = m; mdl_n[r] = n;
    @(posedge clk); #1;
    ld_start = 1'b0;
    check("ld_no_err_on_accept", 64'(ld_err), 64'(0));
    while (k < m * n && cyc < 400) begin
      ld_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      ld_data  = v[k];
      if (poke && cyc == 2) begin
        ld_start = 1'b1; ld_reg = 4'd7; ld_m = 2'd1; ld_n = 2'd1;
      end
      @(negedge clk); hs = ld_valid && ld_ready;
      @(posedge clk); #1;
      cyc++;
      if (hs) k++;
      if (poke && cyc == 3) begin
        ld_start = 1'b0;
        check("ld_err_while_busy", 64'(ld_err), 64'(1));
      end
    end
    ld_valid = 1'b0;
    check("ld_done", 64'(ld_done), 64'(1));
    if (exp_lat > 0) check("ld_latency", 64'(cyc + 1), 64'(exp_lat));
    check("ld_idle_after_done", 64'(ld_busy), 64'(0));
  endtask

  task automatic ld_reject(input int r, input int m, input int n);
    ld_start = 1'b1; ld_reg = RB'(r); ld_m = DB'(m); ld_n = NB'(n);
    @(posedge clk); #1;
    ld_start = 1'b0;
    check("ld_err_pulse", 64'({ld_err, ld_busy}), 64'(2'b10));
    @(posedge clk); #1;
    check("ld_err_one_cycle", 64'({ld_err, ld_busy}), 64'(2'b00));
  endtask

  task automatic store_matrix(input int r, input bit exp_err);
    st_start = 1'b1; st_reg = RB'(r);
    if (!exp_err)
      for (int rr = 0; rr < mdl_m[r]; rr++)
        for (int cc = 0; cc < mdl_n[r]; cc++)
          exp_q.push_back({mdl[r][rr * MAX_N + cc], 2'(rr), 2'(cc),
                           (rr == mdl_m[r] - 1 && cc == mdl_n[r] - 1),
                           2'(mdl_m[r]), 2'(mdl_n[r])});
    @(posedge clk); #1;
    st_start = 1'b0;
    check("st_err", 64'(st_err), 64'(exp_err));
    check("st_busy", 64'(st_busy), 64'(!exp_err));
  endtask

  task automatic wait_store_idle();
    int c = 0;
    while (st_busy && c < 300) begin
      @(posedge clk); #1;
      c++;
    end
    check("st_idle_timeout", 64'(st_busy), 64'(0));
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", outs(), 64'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: 2x3 load of 1.0..6.0 into reg 2, then stream it back
    v = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000, 32'h40A0_0000,
          32'h40C0_0000, 32'h0, 32'h0, 32'h0};
    load_matrix(2, 2, 3, 1'b0, 7, 1'b0);
    store_matrix(2, 1'b0);
    wait_store_idle();

    // 2: illegal dimensions and a never-loaded register
    ld_reject(6, 0, 2);
    ld_reject(6, 2, 4);          // MAX_N+1 does not fit the 2-bit port and wraps to 0
    store_matrix(9, 1'b1);

    // 4: concurrent store of reg 1 and random-valid load of reg 4, ready at 50%
    v = '{32'h11, 32'h12, 32'h13, 32'h14, 32'h15, 32'h16, 32'h0, 32'h0, 32'h0};
    load_matrix(1, 3, 2, 1'b0, 7, 1'b0);
    v = '{32'h41, 32'h42, 32'h43, 32'h44, 32'h45, 32'h46, 32'h47, 32'h48, 32'h49};
    rdy_rand = 1'b1;
    fork
      load_matrix(4, 3, 3, 1'b1, 0, 1'b0);
      store_matrix(1, 1'b0);
    join
    wait_store_idle();
    store_matrix(4, 1'b0);
    wait_store_idle();
    rdy_rand = 1'b0;

    // 3: store reg 5 on the 2nd beat of its own 3x3 load waits and streams the new data
    v = '{32'h51, 32'h52, 32'h53, 32'h54, 32'h55, 32'h56, 32'h57, 32'h58, 32'h59};
    early = 1'b0;
    fork
      load_matrix(5, 3, 3, 1'b0, 10, 1'b1);
      begin
        repeat (2) @(posedge clk);
        #1;
        store_matrix(5, 1'b0);
        for (int i = 0; i < 20 && ld_busy; i++) begin
          if (st_valid) early = 1'b1;
          @(posedge clk); #1;
        end
        check("st_waits_for_load", 64'(early), 64'(0));
      end
    join
    wait_store_idle();

    // 5: reset in the middle of loading reg 3
    ld_start = 1'b1; ld_reg = 4'd3; ld_m = 2'd2; ld_n = 2'd2;
    @(posedge clk); #1;
    ld_start = 1'b0; ld_valid = 1'b1; ld_data = 32'hC1;
    @(posedge clk); #1;
    ld_data = 32'hC2;
    @(posedge clk); #1;
    ld_valid = 1'b0;
    rst_n = 1'b0;
    #2;
    check("reset_mid_load_outputs", outs(), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    store_matrix(3, 1'b1);
    store_matrix(2, 1'b1);

    // 6: clear is ignored during a store and honoured when both ports are idle
    v = '{32'hA1, 32'hA2, 32'hA3, 32'hA4, 32'hA5, 32'hA6, 32'hA7, 32'hA8, 32'hA9};
    load_matrix(1, 3, 3, 1'b0, 10, 1'b0);
    v = '{32'hB1, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    load_matrix(2, 1, 1, 1'b0, 2, 1'b0);
    store_matrix(1, 1'b0);
    ld_reject(1, 1, 1);          // register is being stored
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    wait_store_idle();
    store_matrix(2, 1'b0);
    wait_store_idle();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    store_matrix(1, 1'b1);
    store_matrix(2, 1'b1);
    store_matrix(4, 1'b1);

    repeat (2) @(posedge clk);
    check("scoreboard_empty", 64'(exp_q.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
